// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants and state type for the UART register bridge.
// Command bytes select the bus operation; response bytes are pushed back to the host.
package uart_reg_bridge_pkg;

    localparam logic [7:0] CmdWrite   = 8'h57;
    localparam logic [7:0] CmdRead    = 8'h52;

    localparam logic [7:0] RspAck     = 8'h06;
    localparam logic [7:0] RspNak     = 8'h15;
    localparam logic [7:0] RspTimeout = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

endpackage

// File: rtl/uart_reg_bridge.sv
// UART command bridge: pops W/R frames from the RX FIFO, performs one register
// access on a req/ack bus and pushes the response bytes into the TX FIFO.
// Optional bus ack timeout is enabled by defining UART_REG_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int AddrBytes  = 1,
    parameter int DataBytes  = 4,
    parameter int TimeoutCyc = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx_empty,
    output logic                   o_rx_read,
    input  logic [7:0]             i_rx_rdata,
    input  logic                   i_tx_full,
    output logic                   o_tx_write,
    output logic [7:0]             o_tx_wdata,
    output logic                   o_req,
    output logic                   o_we,
    output logic [8*AddrBytes-1:0] o_addr,
    output logic [8*DataBytes-1:0] o_wdata,
    input  logic                   i_ack,
    input  logic [8*DataBytes-1:0] i_rdata,
    output logic                   o_busy
);

    localparam int AW     = 8 * AddrBytes;
    localparam int DW     = 8 * DataBytes;
    localparam int CntMax = (AddrBytes > DataBytes + 1) ? AddrBytes : DataBytes + 1;
    localparam int CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rdata_q;
    logic [7:0]    resp_code;
    logic          send_data;

    logic          rx_pop;
    logic          tx_push;
    logic          last_resp;
    logic [7:0]    resp_byte;
    logic          tmo_hit;

    // Handshake strobes and the response byte mux; strobes stay quiet while reset is held.
    always_comb begin
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        resp_byte = resp_code;
        last_resp = 1'b0;
        if (i_rst_n && !i_rx_empty && (state inside {IDLE, ADDR, DATA})) begin
            rx_pop = 1'b1;
        end
        if (i_rst_n && !i_tx_full && (state == RESP)) begin
            tx_push = 1'b1;
        end
        if (cnt == '0) begin
            resp_byte = resp_code;
            last_resp = !send_data;
        end else begin
            resp_byte = rdata_q[DW-1 -: 8];
            last_resp = (cnt == CW'(DataBytes));
        end
    end

    assign o_rx_read  = rx_pop;
    assign o_tx_write = tx_push;
    assign o_tx_wdata = tx_push ? resp_byte : 8'h00;
    assign o_busy     = (state != IDLE);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCyc + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TW'(TimeoutCyc - 1));

    // Counts request cycles without ack; an ack on the final counted cycle still wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == BUS) && o_req && !i_ack && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame FSM: collect cmd/addr/data bytes, run the bus cycle, then stream the response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            o_req     <= 1'b0;
            o_we      <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            rdata_q   <= '0;
            resp_code <= 8'h00;
            send_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_pop) begin
                        cnt <= '0;
                        if ((i_rx_rdata == CmdWrite) || (i_rx_rdata == CmdRead)) begin
                            o_we  <= (i_rx_rdata == CmdWrite);
                            state <= ADDR;
                        end else begin
                            resp_code <= RspNak;
                            send_data <= 1'b0;
                            state     <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_pop) begin
                        o_addr <= (o_addr << 8) | AW'(i_rx_rdata);
                        if (cnt == CW'(AddrBytes - 1)) begin
                            cnt   <= '0;
                            state <= o_we ? DATA : BUS;
                            o_req <= !o_we;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx_pop) begin
                        o_wdata <= (o_wdata << 8) | DW'(i_rx_rdata);
                        if (cnt == CW'(DataBytes - 1)) begin
                            cnt   <= '0;
                            state <= BUS;
                            o_req <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BUS: begin
                    // cnt=0 while the request is open; cnt=1 is the turnaround cycle after it closes.
                    if (cnt == '0) begin
                        if (i_ack) begin
                            o_req     <= 1'b0;
                            o_we      <= 1'b0;
                            resp_code <= RspAck;
                            send_data <= !o_we;
                            if (!o_we) begin
                                rdata_q <= i_rdata;
                            end
                            cnt <= CW'(1);
                        end else if (tmo_hit) begin
                            o_req     <= 1'b0;
                            o_we      <= 1'b0;
                            resp_code <= RspTimeout;
                            send_data <= 1'b0;
                            cnt       <= CW'(1);
                        end
                    end else begin
                        cnt   <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (tx_push) begin
                        if (last_resp) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt != '0) begin
                                rdata_q <= rdata_q << 8;
                            end
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
